// File: rtl/fde_pkg.sv
// Shared definitions for the FDE write-back capture block.
// Default widths, shadow size and the log record layout.
package fde_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] add;
        logic [DATA_W-1:0] data;
    } log_rec_t;

    function automatic log_rec_t make_rec(
        input logic [ADDR_W-1:0] add,
        input logic [DATA_W-1:0] data
    );
        log_rec_t r;
        r.add  = add;
        r.data = data;
        return r;
    endfunction

endpackage

// File: rtl/wb_log_fifo.sv
// Synchronous log FIFO with extra-MSB pointers, live count and
// a sticky overflow flag for records dropped while full.
module wb_log_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_rec,
    input  logic          pop_ready,
    output logic          valid,
    output logic [W-1:0]  head,
    output logic [PW-1:0] count,
    output logic          overflow
);

    localparam logic [PW-1:0] ONE      = PW'(1);
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    always_comb begin
        count   = wr_ptr - rd_ptr;
        valid   = (wr_ptr != rd_ptr);
        full    = (count == FULL_CNT);
        do_pop  = valid & pop_ready;
        // A pop on the same edge frees the slot the push needs.
        do_push = push & (~full | do_pop);
        drop    = push & full & ~do_pop;
        head    = valid ? mem[rd_ptr[AW-1:0]] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_rec;
                wr_ptr              <= wr_ptr + ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ONE;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_capture.sv
// Write-back receiver: shadow register file plus a drainable write log.
// Optional WB_DIFF_FILTER_EN logs only writes that change the shadow.
module wb_capture #(
    parameter int ADDR_W    = fde_pkg::ADDR_W,
    parameter int DATA_W    = fde_pkg::DATA_W,
    parameter int LOG_DEPTH = 4,
    localparam int CW       = $clog2(LOG_DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stop,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_write_add,
    input  logic [DATA_W-1:0] i_write_data,
    input  logic [ADDR_W-1:0] i_rd_add,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_log_valid,
    output logic [ADDR_W-1:0] o_log_add,
    output logic [DATA_W-1:0] o_log_data,
    input  logic              i_log_ready,
    output logic [CW-1:0]     o_log_count,
    output logic              o_overflow
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam int RW    = ADDR_W + DATA_W;

    logic [DATA_W-1:0] shadow [NREGS];
    logic              accept;
    logic              push;
    logic [RW-1:0]     head;

    always_comb begin
        accept = i_wr_en & ~i_stop;
`ifdef WB_DIFF_FILTER_EN
        push   = accept & (shadow[i_write_add] != i_write_data);
`else
        push   = accept;
`endif
    end

    // Read samples the pre-edge array, so same-cycle writes show next cycle.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_rd_data <= '0;
            for (int i = 0; i < NREGS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            o_rd_data <= shadow[i_rd_add];
            if (accept) begin
                shadow[i_write_add] <= i_write_data;
            end
        end
    end

    wb_log_fifo #(
        .W     (RW),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk       (i_clk),
        .rst_n     (i_reset),
        .push      (push),
        .push_rec  ({i_write_add, i_write_data}),
        .pop_ready (i_log_ready),
        .valid     (o_log_valid),
        .head      (head),
        .count     (o_log_count),
        .overflow  (o_overflow)
    );

    assign o_log_add  = head[RW-1:DATA_W];
    assign o_log_data = head[DATA_W-1:0];

endmodule

// File: tb/tb_wb_capture.sv
// Self-checking bench for wb_capture using a queue-based reference model.
module tb_wb_capture;
    import fde_pkg::*;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stop = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wa = '0;
    logic [7:0] wd = '0;
    logic [3:0] ra = '0;
    logic       ready = 1'b0;
    logic [7:0] rd_data;
    logic       log_valid;
    logic [3:0] log_add;
    logic [7:0] log_data;
    logic [2:0] log_count;
    logic       overflow;

    int total = 0;
    int bad = 0;

    logic [7:0] m_shadow [16];
    log_rec_t   m_q [$];
    logic       m_ovf;
    logic [7:0] m_rd;

    wb_capture #(.ADDR_W(4), .DATA_W(8), .LOG_DEPTH(D)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_stop       (stop),
        .i_wr_en      (wr_en),
        .i_write_add  (wa),
        .i_write_data (wd),
        .i_rd_add     (ra),
        .o_rd_data    (rd_data),
        .o_log_valid  (log_valid),
        .o_log_add    (log_add),
        .o_log_data   (log_data),
        .i_log_ready  (ready),
        .o_log_count  (log_count),
        .o_overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_shadow[i] = '0;
        m_q.delete();
        m_ovf = 1'b0;
        m_rd  = '0;
    endtask

    // One clock edge; the model applies the rules to the pre-edge inputs.
    task automatic step();
        bit pop, acc, psh;
        @(posedge clk);
        pop = (m_q.size() > 0) && ready;
        acc = wr_en && !stop;
        psh = acc;
`ifdef WB_DIFF_FILTER_EN
        psh = acc && (m_shadow[wa] != wd);
`endif
        m_rd = m_shadow[ra];
        if (pop) void'(m_q.pop_front());
        if (psh) begin
            if (m_q.size() < D) m_q.push_back(make_rec(wa, wd));
            else m_ovf = 1'b1;
        end
        if (acc) m_shadow[wa] = wd;
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        stop  = 1'b0;
        ready = 1'b0;
        model_clear();
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({rd_data, log_valid, log_add, log_data, log_count, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {rd_data, log_valid, log_add, log_data, log_count, overflow});
        end
        for (int i = 0; i < 16; i++) begin
            ra = 4'(i);
            step();
            total++;
            if (rd_data !== 8'h00) begin
                bad++;
                $display("FAIL reset_shadow[%0d] got=%h want=00", i, rd_data);
            end
        end
    endtask

    task automatic test_single_write();
        apply_reset();
        wr_en = 1'b1; wa = 4'h3; wd = 8'hA5; ra = 4'h3;
        step();
        wr_en = 1'b0;
        total++;
        if ({log_valid, log_add, log_data, log_count} !== {1'b1, 4'h3, 8'hA5, 3'd1}) begin
            bad++;
            $display("FAIL single_log got=%b/%h/%h/%0d want=1/3/a5/1",
                     log_valid, log_add, log_data, log_count);
        end
        total++;
        if (rd_data !== 8'h00) begin
            bad++;
            $display("FAIL single_same_cycle_read got=%h want=00", rd_data);
        end
        ready = 1'b1;
        step();
        total++;
        if (rd_data !== 8'hA5) begin
            bad++;
            $display("FAIL single_read got=%h want=a5", rd_data);
        end
        total++;
        if (log_count !== 3'd0 || log_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_pop count=%0d valid=%b want=0/0", log_count, log_valid);
        end
        ready = 1'b0;
    endtask

    task automatic test_stop();
        apply_reset();
        stop = 1'b1; wr_en = 1'b1; wa = 4'h5; wd = 8'h77; ra = 4'h5;
        step();
        stop = 1'b0; wr_en = 1'b0;
        step();
        total++;
        if (rd_data !== 8'h00 || log_count !== 3'd0) begin
            bad++;
            $display("FAIL stop_gate rd=%h count=%0d want=00/0", rd_data, log_count);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wa = 4'(i); wd = 8'(i + 1);
            step();
        end
        wr_en = 1'b0; ra = 4'h4;
        step();
        total++;
        if (log_count !== 3'd4 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_state count=%0d ovf=%b want=4/1", log_count, overflow);
        end
        total++;
        if (rd_data !== 8'h05) begin
            bad++;
            $display("FAIL ovf_shadow4 got=%h want=05", rd_data);
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (log_valid !== 1'b1 || log_data !== 8'(i + 1) || log_add !== 4'(i)) begin
                bad++;
                $display("FAIL ovf_drain%0d got=%b/%h/%h want=1/%h/%h",
                         i, log_valid, log_add, log_data, 4'(i), 8'(i + 1));
            end
            step();
        end
        total++;
        if (log_valid !== 1'b0 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_after valid=%b ovf=%b want=0/1", log_valid, overflow);
        end
        ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wa = 4'(i + 8); wd = 8'(8'h40 + i);
            step();
        end
        wa = 4'h9; wd = 8'h3C; ready = 1'b1;
        step();
        wr_en = 1'b0;
        total++;
        if (log_count !== 3'd4 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL full_pp count=%0d ovf=%b want=4/0", log_count, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                total++;
                if (log_add !== 4'h9 || log_data !== 8'h3C) begin
                    bad++;
                    $display("FAIL full_pp_fourth got=%h/%h want=9/3c", log_add, log_data);
                end
            end
            step();
        end
        ready = 1'b0;
    endtask

    task automatic test_filter();
        int want;
        logic [7:0] want_data [3];
        apply_reset();
        want_data[0] = 8'h10;
`ifdef WB_DIFF_FILTER_EN
        want = 2;
        want_data[1] = 8'h11;
`else
        want = 3;
        want_data[1] = 8'h10;
        want_data[2] = 8'h11;
`endif
        wr_en = 1'b1; wa = 4'h2;
        wd = 8'h10; step();
        wd = 8'h10; step();
        wd = 8'h11; step();
        wr_en = 1'b0;
        total++;
        if (log_count !== 3'(want)) begin
            bad++;
            $display("FAIL filter_count got=%0d want=%0d", log_count, want);
        end
        ready = 1'b1;
        for (int i = 0; i < want; i++) begin
            total++;
            if (log_add !== 4'h2 || log_data !== want_data[i]) begin
                bad++;
                $display("FAIL filter_rec%0d got=%h/%h want=2/%h",
                         i, log_add, log_data, want_data[i]);
            end
            step();
        end
        ready = 1'b0;
    endtask

    task automatic test_random();
        log_rec_t h;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_clear();
                total++;
                if ({rd_data, log_valid, log_count, overflow} !== '0) begin
                    bad++;
                    $display("FAIL mid_reset got=%h want=0",
                             {rd_data, log_valid, log_count, overflow});
                end
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            wr_en = 1'($urandom_range(0, 3) != 0);
            stop  = 1'($urandom_range(0, 7) == 0);
            ready = 1'($urandom_range(0, 2) == 0);
            wa    = 4'($urandom_range(0, 15));
            wd    = 8'($urandom_range(0, 3) == 0 ? $urandom_range(0, 1) : $urandom);
            ra    = 4'($urandom_range(0, 15));
            step();
            total++;
            if (rd_data !== m_rd) begin
                bad++;
                $display("FAIL rnd_rd n=%0d got=%h want=%h", n, rd_data, m_rd);
            end
            total++;
            if (log_count !== 3'(m_q.size()) || overflow !== m_ovf) begin
                bad++;
                $display("FAIL rnd_cnt n=%0d got=%0d/%b want=%0d/%b",
                         n, log_count, overflow, m_q.size(), m_ovf);
            end
            total++;
            if (log_valid !== 1'(m_q.size() > 0)) begin
                bad++;
                $display("FAIL rnd_valid n=%0d got=%b want=%b", n, log_valid, m_q.size() > 0);
            end
            if (m_q.size() > 0) begin
                h = m_q[0];
                total++;
                if (log_add !== h.add || log_data !== h.data) begin
                    bad++;
                    $display("FAIL rnd_head n=%0d got=%h/%h want=%h/%h",
                             n, log_add, log_data, h.add, h.data);
                end
            end
        end
        wr_en = 1'b0; stop = 1'b0; ready = 1'b0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_write();
        test_stop();
        test_overflow();
        test_full_push_pop();
        test_filter();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
